// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: round-robin arbiter of NUM_CH requesters onto one byte-serial RAM port.
// Optional: define IO_FULL_STALL_EN to hold IO-space writes (addr[17:16]==2'b11) while io_full is set.
module mem_arb_lane (
  input  logic rd,
  input  logic wr,
  input  logic stall,
  output logic elig
);
  // write wins over read on the same channel, so a stalled write also hides its read
  assign elig = wr ? !stall : rd;
endmodule

module mem_arbiter_n #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*32-1:0]     ch_wdata,
  input  logic [NUM_CH*3-1:0]      ch_length,
  input  logic [NUM_CH-1:0]        ch_signed,
  input  logic [NUM_CH-1:0]        ch_discard,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH*32-1:0]     ch_rdata,
  output logic                     ram_rw,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [7:0]               ram_w_data,
  input  logic [7:0]               ram_r_data
`ifdef IO_FULL_STALL_EN
  ,
  input  logic                     io_full
`endif
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [2:0]        len;
    logic              sgn;
  } req_t;

  state_t            state, state_nxt;
  req_t              cur;
  logic [CW-1:0]     ptr, gnt, pick;
  logic              pick_vld;
  logic [2:0]        cnt, pick_len, last;
  logic [1:0]        cap;
  logic [31:0]       rbuf, rd_ext;
  logic [NUM_CH-1:0] elig, stall;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
`ifdef IO_FULL_STALL_EN
    assign stall[i] = io_full && (ch_addr[i*ADDR_W+16 +: 2] == 2'b11);
`else
    assign stall[i] = 1'b0;
`endif
    mem_arb_lane u_lane (.rd(ch_read[i]), .wr(ch_write[i]), .stall(stall[i]), .elig(elig[i]));
  end

  // scan farthest-first so the nearest requester after ptr overwrites the rest
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int off = NUM_CH; off >= 1; off--) begin
      if (elig[(int'(ptr) + off) % NUM_CH]) begin
        pick     = CW'((int'(ptr) + off) % NUM_CH);
        pick_vld = 1'b1;
      end
    end
    case (ch_length[int'(pick)*3 +: 3])
      3'd1:    pick_len = 3'd1;
      3'd2:    pick_len = 3'd2;
      default: pick_len = 3'd4;
    endcase
  end

  assign last = cur.len - 3'd1;
  assign cap  = 2'(cnt - 3'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = ch_write[pick] ? WR : RD;
      RD:   if (ch_discard[gnt]) state_nxt = IDLE;
            else if (cnt == last) state_nxt = RDW;
      RDW:  state_nxt = ch_discard[gnt] ? IDLE : DONE;
      WR:   if (cnt == last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= CW'(NUM_CH - 1);
      gnt   <= '0;
      cnt   <= '0;
      rbuf  <= '0;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) begin
        gnt       <= pick;
        cnt       <= '0;
        rbuf      <= '0;
        cur.addr  <= ch_addr[int'(pick)*ADDR_W +: ADDR_W];
        cur.wdata <= ch_wdata[int'(pick)*32 +: 32];
        cur.len   <= pick_len;
        cur.sgn   <= ch_signed[pick];
      end
      if (state == RD || state == WR) cnt <= cnt + 3'd1;
      // the RAM answers one cycle after the address, so capture lags cnt by one
      if ((state == RD && cnt != 3'd0) || state == RDW)
        rbuf[{cap, 3'b000} +: 8] <= ram_r_data;
      if (state == DONE || ((state == RD || state == RDW) && ch_discard[gnt]))
        ptr <= gnt;
    end
  end

  always_comb begin
    case (cur.len)
      3'd1:    rd_ext = {{24{cur.sgn & rbuf[7]}}, rbuf[7:0]};
      3'd2:    rd_ext = {{16{cur.sgn & rbuf[15]}}, rbuf[15:0]};
      default: rd_ext = rbuf;
    endcase
  end

  always_comb begin
    ch_busy    = '0;
    ch_ready   = '0;
    ch_rdata   = '0;
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    if (state != IDLE) ch_busy[gnt] = 1'b1;
    case (state)
      RD: ram_addr = cur.addr + ADDR_W'(cnt);
      WR: begin
        ram_rw     = 1'b1;
        ram_addr   = cur.addr + ADDR_W'(cnt);
        ram_w_data = cur.wdata[{cnt[1:0], 3'b000} +: 8];
      end
      DONE: begin
        ch_ready[gnt]              = 1'b1;
        ch_rdata[int'(gnt)*32 +: 32] = rd_ext;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: vector table of single transactions plus multi-cycle sequences.
module tb_mem_arbiter_n;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        ch_read = '0, ch_write = '0, ch_signed = '0, ch_discard = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
  logic [NUM_CH*32-1:0]     ch_wdata = '0;
  logic [NUM_CH*3-1:0]      ch_length = '0;
  logic [NUM_CH-1:0]        ch_busy, ch_ready;
  logic [NUM_CH*32-1:0]     ch_rdata;
  logic                     ram_rw;
  logic [ADDR_W-1:0]        ram_addr;
  logic [7:0]               ram_w_data;
  logic [7:0]               ram_r_data = '0;
`ifdef IO_FULL_STALL_EN
  logic                     io_full = 1'b0;
`endif

  mem_arbiter_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_length(ch_length), .ch_signed(ch_signed), .ch_discard(ch_discard),
    .ch_busy(ch_busy), .ch_ready(ch_ready), .ch_rdata(ch_rdata),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
`ifdef IO_FULL_STALL_EN
    , .io_full(io_full)
`endif
  );

  always #5 clock = ~clock;

  // byte RAM: read data one cycle after address, writes land at the edge; preload port for the bench
  logic [7:0]  mem [logic [31:0]];
  logic        pre_we = 1'b0;
  logic [31:0] pre_a = '0, pre_d = '0;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_rd(a + 3), mem_rd(a + 2), mem_rd(a + 1), mem_rd(a)};
  endfunction

  always @(posedge clock) begin
    ram_r_data <= mem_rd(ram_addr);
    if (pre_we) begin
      for (int k = 0; k < 4; k++) mem[pre_a + k] = pre_d[8*k +: 8];
    end else if (ram_rw) begin
      mem[ram_addr] = ram_w_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    ch_read = '0; ch_write = '0; ch_discard = '0; ch_signed = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_req(input int ch, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] len, input bit sgn);
    ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_wdata[ch*32 +: 32]        = wdata;
    ch_length[ch*3 +: 3]         = len;
    ch_signed[ch]                = sgn;
    ch_read[ch]                  = rd;
    ch_write[ch]                 = wr;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  typedef struct {
    int          ch;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  len;
    bit          sgn;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          nb;
    int          exp_n;
  } vec_t;

  vec_t vec [10];

  // called in an IDLE cycle; the next edge is the grant edge T
  task automatic run_vec(input int idx);
    vec_t v;
    int n;
    logic busy0, bus_ok;
    logic [31:0] rdv, wd;
    v = vec[idx];
    preload(v.addr, v.pre);
    set_req(v.ch, v.rd, v.wr, v.addr, v.wdata, v.len, v.sgn);
    n = 99; busy0 = 1'b0; bus_ok = 1'b1; rdv = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) busy0 = ch_busy[v.ch];
      if (c < v.nb) begin
        wd = v.wdata >> (8*c);
        if (v.wr) bus_ok &= (ram_rw == 1'b1) && (ram_addr == v.addr + 32'(c)) && (ram_w_data == wd[7:0]);
        else      bus_ok &= (ram_rw == 1'b0) && (ram_addr == v.addr + 32'(c));
      end
      if (ch_ready[v.ch]) begin
        n = c;
        rdv = ch_rdata[v.ch*32 +: 32];
        break;
      end
    end
    ch_read[v.ch] = 1'b0; ch_write[v.ch] = 1'b0;
    step();
    chk($sformatf("vec%0d_latency", idx), 64'(n), 64'(v.exp_n));
    chk($sformatf("vec%0d_busy", idx), 64'(busy0), 64'd1);
    chk($sformatf("vec%0d_bus", idx), 64'(bus_ok), 64'd1);
    chk($sformatf("vec%0d_rdata", idx), 64'(rdv), 64'(v.exp_rdata));
    chk($sformatf("vec%0d_mem", idx), 64'(mem_word(v.addr)), 64'(v.exp_mem));
  endtask

  initial begin
    int n;
    logic ok;
    logic [31:0] rdv;

    //            ch rd wr addr       wdata         len sgn pre           rdata         mem           nb n
    vec[0] = '{0, 1, 0, 32'h100,   32'h0,        3'd4, 0, 32'h44332211, 32'h44332211, 32'h44332211, 4, 5};
    vec[1] = '{1, 0, 1, 32'h30000, 32'h0000BEEF, 3'd2, 0, 32'hCCCCCCCC, 32'h0,        32'hCCCCBEEF, 2, 2};
    vec[2] = '{0, 1, 0, 32'h200,   32'h0,        3'd1, 1, 32'h7F7F7F80, 32'hFFFFFF80, 32'h7F7F7F80, 1, 2};
    vec[3] = '{0, 1, 0, 32'h200,   32'h0,        3'd1, 0, 32'h7F7F7F80, 32'h00000080, 32'h7F7F7F80, 1, 2};
    vec[4] = '{1, 1, 0, 32'h300,   32'h0,        3'd2, 1, 32'h55559234, 32'hFFFF9234, 32'h55559234, 2, 3};
    vec[5] = '{1, 1, 0, 32'h300,   32'h0,        3'd2, 0, 32'h55559234, 32'h00009234, 32'h55559234, 2, 3};
    vec[6] = '{0, 1, 0, 32'h400,   32'h0,        3'd3, 1, 32'h84030201, 32'h84030201, 32'h84030201, 4, 5};
    vec[7] = '{0, 0, 1, 32'h500,   32'hA1B2C3D4, 3'd4, 0, 32'h0,        32'h0,        32'hA1B2C3D4, 4, 4};
    vec[8] = '{1, 1, 1, 32'h600,   32'h0000005A, 3'd1, 0, 32'h00000077, 32'h0,        32'h0000005A, 1, 1};
    vec[9] = '{0, 0, 1, 32'h700,   32'h01020304, 3'd0, 0, 32'hFFFFFFFF, 32'h0,        32'h01020304, 4, 4};

    reset_dut();
    chk("reset_handshake", {ch_busy, ch_ready}, '0);
    chk("reset_rdata", ch_rdata, '0);
    chk("reset_bus", {ram_rw, ram_addr, ram_w_data}, '0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // round robin: both channels hold reads; grants alternate with a DONE+IDLE gap
    reset_dut();
    set_req(0, 1, 0, 32'h200, 32'h0, 3'd1, 0);
    set_req(1, 1, 0, 32'h300, 32'h0, 3'd1, 0);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ch_busy != '0) begin ok = 1'b1; break; end
    end
    chk("rr_first_grant", 64'(ok), 64'd1);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] g, eb, er;
      if (i > 0) step();
      g  = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
      eb = (i % 4 < 3) ? g : 2'b00;
      er = (i % 4 == 2) ? g : 2'b00;
      chk($sformatf("rr_cycle%0d", i), {ch_busy, ch_ready}, {eb, er});
    end
    ch_read = '0;
    repeat (6) step();

    // discard of the granted read: no ready, back to IDLE, pointer moves so ch1 wins over ch0
    reset_dut();
    set_req(0, 1, 0, 32'h100, 32'h0, 3'd4, 0);
    set_req(1, 1, 0, 32'h200, 32'h0, 3'd1, 0);
    step();
    chk("disc_busy_t1", ch_busy, 2'b01);
    step();
    ch_discard = 2'b01;
    chk("disc_ready_t2", ch_ready, 2'b00);
    step();
    ch_discard = 2'b00;
    chk("disc_idle_t3", {ch_busy, ch_ready}, 4'b0000);
    step();
    chk("disc_ch1_grant", ch_busy, 2'b10);
    ch_discard = 2'b01;
    step();
    ch_discard = 2'b00;
    n = 99; rdv = '0;
    for (int c = 0; c < 10; c++) begin
      if (ch_ready[1]) begin n = c; rdv = ch_rdata[63:32]; break; end
      step();
    end
    chk("disc_other_latency", 64'(n), 64'd1);
    chk("disc_other_rdata", rdv, 32'h00000080);
    ch_read = '0;
    repeat (8) step();

    // discard during a write is ignored
    reset_dut();
    set_req(0, 0, 1, 32'h800, 32'h00001234, 3'd2, 0);
    step();
    ch_discard = 2'b01;
    step();
    ch_discard = 2'b00;
    chk("wdisc_busy", ch_busy, 2'b01);
    step();
    chk("wdisc_ready", ch_ready, 2'b01);
    ch_write = '0;
    step();
    chk("wdisc_mem", mem_word(32'h800), 32'h00001234);

    // reset mid-write: outputs drop at once, partial bytes stay in RAM
    reset_dut();
    set_req(0, 0, 1, 32'h900, 32'hDEADBEEF, 3'd4, 0);
    step();
    step();
    reset = 1'b1;
    ch_write = '0;
    step();
    chk("midrst_out", {ch_busy, ch_ready, ram_rw, ram_addr, ram_w_data}, '0);
    reset = 1'b0;
    step();
    chk("midrst_mem", mem_word(32'h900), 32'h0000BEEF);

`ifdef IO_FULL_STALL_EN
    reset_dut();
    io_full = 1'b1;
    set_req(1, 0, 1, 32'h30010, 32'h00000099, 3'd1, 0);
    set_req(0, 1, 0, 32'h200, 32'h0, 3'd1, 0);
    n = 99;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ch_ready[0]) begin n = c; break; end
    end
    chk("io_ch0_served", 64'(n), 64'd2);
    ch_read = '0;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      ok &= (ch_busy == 2'b00);
    end
    chk("io_ch1_held", 64'(ok), 64'd1);
    io_full = 1'b0;
    step();
    chk("io_ch1_grant", ch_busy, 2'b10);
    repeat (2) step();
    ch_write = '0;
    step();
    chk("io_mem", 64'(mem_rd(32'h30010)), 64'h99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
